// File: rtl/tilelink_ad_master_if.sv
// Command/response stream plus TileLink-UL A/D channel signals of tilelink_ad_master.
// master = the initiator block, slave = the command source / TileLink slave side.
interface tilelink_ad_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [3:0]  cmd_size;
    logic [3:0]  cmd_mask;
    logic [31:0] cmd_wdata;

    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_bits_opcode;
    logic [2:0]  a_bits_param;
    logic [3:0]  a_bits_size;
    logic        a_bits_source;
    logic [31:0] a_bits_address;
    logic [3:0]  a_bits_mask;
    logic [31:0] a_bits_data;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic        d_bits_source;
    logic        d_bits_sink;
    logic [31:0] d_bits_data;
    logic        d_bits_error;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        rsp_last;

    logic        proto_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_size, cmd_mask, cmd_wdata,
        output cmd_ready,
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
        output a_bits_address, a_bits_mask, a_bits_data,
        input  a_ready,
        input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
        input  d_bits_sink, d_bits_data, d_bits_error,
        output d_ready,
        output rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_last,
        input  rsp_ready,
        output proto_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_size, cmd_mask, cmd_wdata,
        input  cmd_ready,
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
        input  a_bits_address, a_bits_mask, a_bits_data,
        output a_ready,
        output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
        output d_bits_sink, d_bits_data, d_bits_error,
        input  d_ready,
        input  rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_last,
        output rsp_ready,
        input  proto_err
    );
endinterface

// File: rtl/tilelink_ad_master.sv
// Single-outstanding TileLink-UL initiator: one command -> one Get/Put on A, D beats
// streamed back as responses, with protocol checking and response timeout.
module tilelink_ad_master #(
    parameter int MAX_SIZE = 6,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    tilelink_ad_master_if.master bus
);
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, REJ} state_t;

    function automatic logic [3:0] size_mask(input logic [3:0] size, input logic [1:0] addr_lo);
        if (size == 4'd0) return 4'b0001 << addr_lo;
        if (size == 4'd1) return addr_lo[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [4:0] beats_for(input logic [3:0] size);
        if (size <= 4'd2) return 5'd1;
        return 5'd1 << (size - 4'd2);
    endfunction

    function automatic logic cmd_legal(input logic write, input logic [31:0] address,
                                       input logic [3:0] size);
        logic [31:0] align;
        align = (32'd1 << size) - 32'd1;
        return (int'(size) <= MAX_SIZE) && ((address & align) == 32'd0)
            && !(write && size > 4'd2);
    endfunction

    state_t      state;
    logic [2:0]  opcode_q;
    logic [3:0]  size_q;
    logic [31:0] address_q;
    logic [3:0]  mask_q;
    logic [31:0] data_q;
    logic        is_get_q;
    logic        source_q;
    logic        txn_source_q;
    logic [4:0]  beats_q;
    logic [4:0]  beat_count_q;
    logic [15:0] timeout_count_q;
    logic        proto_err_q;

    logic timed_out;
    logic last_beat;
    logic d_fire;
    logic d_bad;

    assign timed_out = (state == RESP) && (TIMEOUT != 0) && (int'(timeout_count_q) == TIMEOUT);
    assign last_beat = (beat_count_q + 5'd1) == beats_q;
    assign d_fire    = (state == RESP) && !timed_out && bus.d_valid && bus.rsp_ready;
    assign d_bad     = (bus.d_bits_opcode != (is_get_q ? OP_ACK_DATA : OP_ACK))
                    || (bus.d_bits_source != txn_source_q)
                    || (bus.d_bits_size != size_q);

    // Param and sink carry no information this initiator acts on.
    logic unused_d_fields;
    assign unused_d_fields = ^{bus.d_bits_param, bus.d_bits_sink};

    // Handshakes decode the registered state; every output is held at zero during reset.
    assign bus.cmd_ready = !reset && (state == IDLE);
    assign bus.a_valid   = !reset && (state == REQ);
    assign bus.d_ready   = !reset && ((state == IDLE)
                                   || ((state == RESP) && !timed_out && bus.rsp_ready));

    assign bus.a_bits_opcode  = reset ? 3'd0  : opcode_q;
    assign bus.a_bits_param   = 3'd0;
    assign bus.a_bits_size    = reset ? 4'd0  : size_q;
    assign bus.a_bits_source  = reset ? 1'b0  : source_q;
    assign bus.a_bits_address = reset ? 32'd0 : address_q;
    assign bus.a_bits_mask    = reset ? 4'd0  : mask_q;
    assign bus.a_bits_data    = reset ? 32'd0 : data_q;

    // D beats pass straight through to the response stream; timeout/reject are synthetic.
    assign bus.rsp_valid   = !reset && (((state == RESP) && (timed_out || bus.d_valid))
                                      || (state == REJ));
    assign bus.rsp_data    = (!reset && (state == RESP) && !timed_out) ? bus.d_bits_data : 32'd0;
    assign bus.rsp_error   = !reset && ((state == REJ)
                                      || ((state == RESP) && (timed_out || bus.d_bits_error)));
    assign bus.rsp_timeout = !reset && timed_out;
    assign bus.rsp_last    = !reset && ((state == REJ)
                                      || ((state == RESP) && (timed_out || last_beat)));
    assign bus.proto_err   = !reset && proto_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            source_q        <= 1'b0;
            proto_err_q     <= 1'b0;
            beat_count_q    <= 5'd0;
            timeout_count_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.d_valid) proto_err_q <= 1'b1;
                    if (bus.cmd_valid) begin
                        is_get_q  <= !bus.cmd_write;
                        size_q    <= bus.cmd_size;
                        address_q <= bus.cmd_address;
                        data_q    <= bus.cmd_wdata;
                        beats_q   <= beats_for(bus.cmd_size);
                        if (bus.cmd_write) begin
                            mask_q   <= bus.cmd_mask;
                            opcode_q <= (bus.cmd_mask == size_mask(bus.cmd_size, bus.cmd_address[1:0]))
                                      ? OP_PUT_FULL : OP_PUT_PARTIAL;
                        end else begin
                            mask_q   <= size_mask(bus.cmd_size, bus.cmd_address[1:0]);
                            opcode_q <= OP_GET;
                        end
                        state <= cmd_legal(bus.cmd_write, bus.cmd_address, bus.cmd_size) ? REQ : REJ;
                    end
                end
                REQ: begin
                    if (bus.a_ready) begin
                        txn_source_q    <= source_q;
                        source_q        <= !source_q;
                        beat_count_q    <= 5'd0;
                        timeout_count_q <= 16'd0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (timed_out) begin
                        if (bus.rsp_ready) state <= IDLE;
                    end else if (d_fire) begin
                        if (d_bad) proto_err_q <= 1'b1;
                        timeout_count_q <= 16'd0;
                        if (last_beat) state <= IDLE;
                        else           beat_count_q <= beat_count_q + 5'd1;
                    end else begin
                        timeout_count_q <= timeout_count_q + 16'd1;
                    end
                end
                REJ: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
